// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory responder: FSM state
// encoding, line geometry and the line-index helper.
package main_mem_pkg;

    localparam int LINE_W      = 128;
    localparam int ADDR_W      = 32;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_state_t;

    // Full line number of a byte address; callers truncate to their array depth,
    // which is what makes addresses alias modulo the array size.
    function automatic logic [ADDR_W-OFFSET_BITS-1:0] line_index(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_BITS];
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// MEM_LINES x 128-bit line store: synchronous write port, asynchronous read port.
// Contents are zeroed at configuration/time 0 only, never by reset.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int MEM_LINES = 4096,
    parameter int IDX_W     = $clog2(MEM_LINES)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LINE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] rd_data
);

    logic [LINE_W-1:0] mem [MEM_LINES] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/main_mem_resp.sv
// Main-memory responder: accepts line requests, answers after LATENCY cycles
// with a one-cycle mem_data_ready pulse. MAIN_MEM_STATS_EN adds rd/wr counters.
module main_mem_resp
    import main_mem_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_LINES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_data,
    output logic              mem_data_ready,
    output logic [LINE_W-1:0] mem_data_data,
    output logic              req_overrun
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int         IDX_W    = $clog2(MEM_LINES);
    // WAIT spans LATENCY-1 cycles; the counter runs down to zero inclusive.
    localparam logic [7:0] CNT_LOAD = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

    mem_state_t        state;
    logic [7:0]        cnt;
    logic              rw_q;
    logic [IDX_W-1:0]  idx_q;

    logic              accept;
    logic              to_resp;
    logic              resp_rw;
    logic              wr_en;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [LINE_W-1:0] rd_data;

    assign req_idx = IDX_W'(line_index(mem_req_addr));
    assign accept  = mem_req_valid && (state == IDLE || state == RESP);
    assign wr_en   = accept && mem_req_rw && rst;

    // With LATENCY=1 the request goes straight to RESP, so the read port must
    // see the incoming index rather than the latched one.
    assign to_resp = (accept && LATENCY == 1) || (state == WAIT && cnt == 8'd0);
    assign resp_rw = accept ? mem_req_rw : rw_q;
    assign rd_idx  = accept ? req_idx : idx_q;

    main_mem_array #(
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (req_idx),
        .wr_data (mem_req_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            rw_q           <= 1'b0;
            idx_q          <= '0;
            mem_data_ready <= 1'b0;
            mem_data_data  <= '0;
            req_overrun    <= 1'b0;
        end else begin
            mem_data_ready <= to_resp;
            mem_data_data  <= (to_resp && !resp_rw) ? rd_data : '0;
            if (mem_req_valid && state == WAIT)
                req_overrun <= 1'b1;
            if (accept) begin
                rw_q  <= mem_req_rw;
                idx_q <= req_idx;
            end
            case (state)
                IDLE, RESP: begin
                    if (!accept)
                        state <= IDLE;
                    else if (LATENCY == 1)
                        state <= RESP;
                    else begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt == 8'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAIN_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (accept) begin
            if (mem_req_rw)
                wr_count <= wr_count + 32'd1;
            else
                rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_main_mem_resp.sv
// Bench for main_mem_resp: a LATENCY=4 and a LATENCY=1 instance driven by
// directed and random requests, checked against a line-indexed memory model.
module tb_main_mem_resp;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         v = 1'b0;
    logic         req_rw = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    int           sel = 0;

    logic         rdy4, rdy1, ovr4, ovr1, rdy, ovr;
    logic [127:0] dat4, dat1, dat;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0]  rdc4, wrc4, rdc1, wrc1;
`endif

    int errors = 0;
    int checks = 0;
    logic [127:0] model [int];
    int rdm [2];
    int wrm [2];

    always #5 clk = ~clk;

    assign rdy = sel ? rdy1 : rdy4;
    assign dat = sel ? dat1 : dat4;
    assign ovr = sel ? ovr1 : ovr4;

    main_mem_resp #(.LATENCY(4), .MEM_LINES(4096)) u4 (
        .clk(clk), .rst(rst), .mem_req_valid(v && sel == 0), .mem_req_rw(req_rw),
        .mem_req_addr(req_addr), .mem_req_data(req_data),
        .mem_data_ready(rdy4), .mem_data_data(dat4), .req_overrun(ovr4)
`ifdef MAIN_MEM_STATS_EN
        , .rd_count(rdc4), .wr_count(wrc4)
`endif
    );

    main_mem_resp #(.LATENCY(1), .MEM_LINES(4096)) u1 (
        .clk(clk), .rst(rst), .mem_req_valid(v && sel == 1), .mem_req_rw(req_rw),
        .mem_req_addr(req_addr), .mem_req_data(req_data),
        .mem_data_ready(rdy1), .mem_data_data(dat1), .req_overrun(ovr1)
`ifdef MAIN_MEM_STATS_EN
        , .rd_count(rdc1), .wr_count(wrc1)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", rdy, 1'b0);
            check("idle_data", dat, '0);
        end
    endtask

`ifdef MAIN_MEM_STATS_EN
    task automatic stats_check(input string tag);
        check({tag, "_rd"}, sel ? rdc1 : rdc4, 32'(rdm[sel]));
        check({tag, "_wr"}, sel ? wrc1 : wrc4, 32'(wrm[sel]));
    endtask
`endif

    // Issue one request at this negedge and follow it to its pulse. Returns at
    // the negedge where ready is observed high, so a following call is back-to-back.
    // ovr_at>0 injects a conflicting write to the same line while the block waits.
    task automatic run_req(input logic rw, input logic [31:0] a, input logic [127:0] d, input int ovr_at);
        int lat;
        int key;
        logic [127:0] exp;
        lat = sel ? 1 : 4;
        key = sel * 65536 + int'((a >> 4) % 4096);
        exp = (!rw && model.exists(key)) ? model[key] : '0;
        if (rw) begin
            model[key] = d;
            wrm[sel]++;
        end else
            rdm[sel]++;
        req_rw = rw; req_addr = a; req_data = d; v = 1'b1;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            v = (i == ovr_at);
            if (i == ovr_at) begin
                req_rw   = 1'b1;
                req_data = ~d;
            end
            check("resp_ready", rdy, (i == lat));
            check("resp_data", dat, (i == lat) ? exp : '0);
        end
        v = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        rdm = '{0, 0};
        wrm = '{0, 0};

        // reset held three cycles, then idle
        repeat (3) begin
            @(negedge clk);
            check("rst_ready4", rdy4, 1'b0); check("rst_data4", dat4, '0); check("rst_ovr4", ovr4, 1'b0);
            check("rst_ready1", rdy1, 1'b0); check("rst_data1", dat1, '0); check("rst_ovr1", ovr1, 1'b0);
        end
        rst = 1'b1;
        idle(4);
        check("idle_ovr4", ovr4, 1'b0);
        check("idle_ovr1", ovr1, 1'b0);

        // write then read, LATENCY=4
        sel = 0;
        run_req(1'b1, 32'h0000_1230, 128'h44444444_33333333_22222222_11111111, 0);
        idle(2);
        run_req(1'b0, 32'h0000_1238, 128'h0, 0);
        check("wr_rd_const", dat4, 128'h44444444_33333333_22222222_11111111);
        idle(1);

        // back-to-back: read accepted in the ready cycle
        run_req(1'b1, 32'h0000_0040, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0);
        run_req(1'b0, 32'h0000_0080, 128'h0, 0);
        run_req(1'b0, 32'h0000_0044, 128'h0, 0);
        idle(2);

        // overrun: ignored write in WAIT must not reach the array
        check("ovr_before", ovr4, 1'b0);
        run_req(1'b0, 32'h0000_1230, 128'h0, 2);
        check("ovr_set", ovr4, 1'b1);
        idle(5);
        run_req(1'b0, 32'h0000_1230, 128'h0, 0);
        idle(1);
        check("ovr_sticky", ovr4, 1'b1);
        check("ovr_other_inst", ovr1, 1'b0);

        // LATENCY=1 with address wrap, back-to-back pulses
        sel = 1;
        run_req(1'b1, 32'h0001_0000, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 0);
        run_req(1'b0, 32'h0000_0000, 128'h0, 0);
        check("wrap_const", dat1, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF);
        idle(2);

        // random traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            idle(1);
            for (int n = 0; n < 40; n++) begin
                a = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
                run_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom}, 0);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
            idle(2);
`ifdef MAIN_MEM_STATS_EN
            stats_check("stats_rand");
`endif
        end

        // reset mid-operation: read abandoned in WAIT
        sel = 0;
        req_rw = 1'b0; req_addr = 32'h0000_0040; v = 1'b1;
        @(negedge clk);
        v = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rdm = '{0, 0};
        wrm = '{0, 0};
        check("midrst_ready", rdy4, 1'b0);
        check("midrst_ovr", ovr4, 1'b0);
        idle(6);
`ifdef MAIN_MEM_STATS_EN
        stats_check("stats_after_rst");
`endif
        run_req(1'b0, 32'h0000_0040, 128'h0, 0);
        run_req(1'b0, 32'h0000_1230, 128'h0, 0);
        idle(2);
`ifdef MAIN_MEM_STATS_EN
        stats_check("stats_two_reads");
`endif
        check("final_ovr", ovr4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
